// File: rtl/pulse_window_counter_pkg.sv
// Shared types and constants for the pulse window counter and its rise-edge helper.
package pulse_win_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam int DEF_CNT_W = 8;
    localparam int DEF_WIN_W = 16;

    // All-ones value of a w-bit counter, used as the saturation ceiling.
    function automatic logic [31:0] sat_max(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/pulse_window_counter_rise_edge.sv
// Rising-edge detector on a same-domain pulse; the history flop tracks the input every cycle.
module pulse_rise_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic pulse_in,
    output logic rise
);

    logic pulse_prev_d, pulse_prev_q;

    always_comb begin
        pulse_prev_d = pulse_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_prev_q <= 1'b0;
        end else begin
            pulse_prev_q <= pulse_prev_d;
        end
    end

    assign rise = pulse_in & ~pulse_prev_q;

endmodule

// File: rtl/pulse_window_counter.sv
// Counts detector rising edges over programmable windows and hands each count out on valid/ready.
// Optional threshold alarm output is built when PULSE_WIN_THRESH_EN is defined.
module pulse_window_counter
    import pulse_win_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int WIN_W = DEF_WIN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIN_W-1:0] win_len,
    input  logic             pulse_in,
    output logic [CNT_W-1:0] cnt_data,
    output logic             cnt_valid,
    input  logic             cnt_ready,
    output logic             cnt_ovf,
`ifdef PULSE_WIN_THRESH_EN
    input  logic [CNT_W-1:0] thresh,
    output logic             alarm,
`endif
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

    state_e           state_d, state_q;
    logic [WIN_W-1:0] timer_d, timer_q;
    logic [CNT_W-1:0] acc_d, acc_q;
    logic             ovf_acc_d, ovf_acc_q;
    logic [CNT_W-1:0] cnt_data_d, cnt_data_q;
    logic             cnt_valid_d, cnt_valid_q;
    logic             cnt_ovf_d, cnt_ovf_q;
    logic             busy_d, busy_q;
    logic             rise;
    logic             start;
    logic             final_cycle;
    logic [CNT_W-1:0] acc_inc;
    logic             ovf_inc;

    pulse_rise_edge u_rise (
        .clk      (clk),
        .rst_n    (rst_n),
        .pulse_in (pulse_in),
        .rise     (rise)
    );

    // Count including this cycle's edge, so a rise on the last window cycle lands in the result.
    assign acc_inc     = (rise && (acc_q != CNT_MAX)) ? acc_q + 1'b1 : acc_q;
    assign ovf_inc     = ovf_acc_q | (rise && (acc_q == CNT_MAX));
    assign final_cycle = (state_q == COUNT) && enable && (timer_q == '0);

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        acc_d       = acc_q;
        ovf_acc_d   = ovf_acc_q;
        cnt_data_d  = cnt_data_q;
        cnt_valid_d = cnt_valid_q;
        cnt_ovf_d   = cnt_ovf_q;
        start       = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    start = 1'b1;
                end
            end
            COUNT: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (timer_q == '0) begin
                    state_d     = HOLD;
                    cnt_data_d  = acc_inc;
                    cnt_ovf_d   = ovf_inc;
                    cnt_valid_d = 1'b1;
                end else begin
                    timer_d   = timer_q - 1'b1;
                    acc_d     = acc_inc;
                    ovf_acc_d = ovf_inc;
                end
            end
            HOLD: begin
                if (cnt_ready) begin
                    cnt_valid_d = 1'b0;
                    if (enable) begin
                        start = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A zero window length behaves as a single-cycle window.
        if (start) begin
            state_d   = COUNT;
            timer_d   = (win_len == '0) ? '0 : win_len - 1'b1;
            acc_d     = '0;
            ovf_acc_d = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            acc_q       <= '0;
            ovf_acc_q   <= 1'b0;
            cnt_data_q  <= '0;
            cnt_valid_q <= 1'b0;
            cnt_ovf_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            acc_q       <= acc_d;
            ovf_acc_q   <= ovf_acc_d;
            cnt_data_q  <= cnt_data_d;
            cnt_valid_q <= cnt_valid_d;
            cnt_ovf_q   <= cnt_ovf_d;
            busy_q      <= busy_d;
        end
    end

    assign cnt_data  = cnt_data_q;
    assign cnt_valid = cnt_valid_q;
    assign cnt_ovf   = cnt_ovf_q;
    assign busy      = busy_q;

`ifdef PULSE_WIN_THRESH_EN
    logic alarm_d, alarm_q;

    always_comb begin
        alarm_d = alarm_q;
        if (final_cycle) begin
            alarm_d = (acc_inc >= thresh);
        end else if ((state_q == HOLD) && cnt_ready) begin
            alarm_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alarm_q <= 1'b0;
        end else begin
            alarm_q <= alarm_d;
        end
    end

    assign alarm = alarm_q;
`else
    logic unused_final_cycle;
    assign unused_final_cycle = final_cycle;
`endif

endmodule

// File: tb/tb_pulse_window_counter.sv
// Self-checking bench for pulse_window_counter (CNT_W=4): directed window table, corner sequences, random run.
module tb_pulse_window_counter;

    localparam int N = 600;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] win_len = '0;
    logic        pulse_in = 1'b0;
    logic [3:0]  cnt_data;
    logic        cnt_valid;
    logic        cnt_ready = 1'b0;
    logic        cnt_ovf;
    logic        busy;
`ifdef PULSE_WIN_THRESH_EN
    logic [3:0]  thresh = '0;
    logic        alarm;
`endif

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    pulse_window_counter #(.CNT_W(4), .WIN_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .win_len   (win_len),
        .pulse_in  (pulse_in),
        .cnt_data  (cnt_data),
        .cnt_valid (cnt_valid),
        .cnt_ready (cnt_ready),
        .cnt_ovf   (cnt_ovf),
`ifdef PULSE_WIN_THRESH_EN
        .thresh    (thresh),
        .alarm     (alarm),
`endif
        .busy      (busy)
    );

    typedef struct {
        logic [15:0] wl;
        logic [63:0] mask;
        logic        pre;
        int          hold;
        logic [3:0]  th;
        logic [3:0]  exp_d;
        logic        exp_o;
    } vec_t;

    vec_t tbl[11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_window(input int idx, input vec_t v);
        int len;
        len = (v.wl == 16'd0) ? 1 : int'(v.wl);
        enable    = 1'b0;
        cnt_ready = 1'b0;
        pulse_in  = v.pre;
`ifdef PULSE_WIN_THRESH_EN
        thresh = v.th;
`endif
        tick();
        enable  = 1'b1;
        win_len = v.wl;
        tick();
        chk("t_busy_start", 32'(busy), 32'd1);
        for (int j = 0; j < len; j++) begin
            pulse_in = v.mask[j];
            win_len  = 16'($urandom_range(0, 50));
            tick();
            if (j < len - 1) chk("t_valid_early", 32'(cnt_valid), 32'd0);
        end
        chk("t_valid", 32'(cnt_valid), 32'd1);
        chk("t_data", 32'(cnt_data), 32'(v.exp_d));
        chk("t_ovf", 32'(cnt_ovf), 32'(v.exp_o));
`ifdef PULSE_WIN_THRESH_EN
        chk("t_alarm", 32'(alarm), 32'(v.exp_d >= v.th));
`endif
        $display("[TB] window %0d wl=%0d data=%0d ovf=%0d", idx, v.wl, cnt_data, cnt_ovf);
        for (int j = 0; j < v.hold; j++) begin
            pulse_in = (j % 2 == 0);
            enable   = (j % 3 == 0);
            tick();
            chk("h_valid", 32'(cnt_valid), 32'd1);
            chk("h_data", 32'(cnt_data), 32'(v.exp_d));
            chk("h_ovf", 32'(cnt_ovf), 32'(v.exp_o));
            chk("h_busy", 32'(busy), 32'd1);
        end
        enable    = 1'b0;
        cnt_ready = 1'b1;
        tick();
        chk("hs_valid", 32'(cnt_valid), 32'd0);
        chk("hs_busy", 32'(busy), 32'd0);
`ifdef PULSE_WIN_THRESH_EN
        chk("hs_alarm", 32'(alarm), 32'd0);
`endif
        cnt_ready = 1'b0;
        pulse_in  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        bit   p[N];
        bit   rdy[N];
        int   wl[N];
        int   s_e, e_e, raw;
        logic [3:0] exp_d;
        logic exp_o, exp_v;

        // Reset state
        tick();
        tick();
        chk("rst_valid", 32'(cnt_valid), 32'd0);
        chk("rst_data", 32'(cnt_data), 32'd0);
        chk("rst_ovf", 32'(cnt_ovf), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
`ifdef PULSE_WIN_THRESH_EN
        chk("rst_alarm", 32'(alarm), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);

        // Directed windows
        tbl[0]  = '{16'd10, 64'h92,          1'b0, 0, 4'd3,  4'd3,  1'b0};
        tbl[1]  = '{16'd10, 64'h12,          1'b0, 0, 4'd3,  4'd2,  1'b0};
        tbl[2]  = '{16'd10, 64'hFC,          1'b0, 2, 4'd3,  4'd1,  1'b0};
        tbl[3]  = '{16'd10, 64'h3FF,         1'b1, 0, 4'd0,  4'd0,  1'b0};
        tbl[4]  = '{16'd40, 64'h55_5555_5555, 1'b0, 0, 4'd15, 4'd15, 1'b1};
        tbl[5]  = '{16'd10, 64'h92,          1'b0, 7, 4'd3,  4'd3,  1'b0};
        tbl[6]  = '{16'd0,  64'h1,           1'b0, 0, 4'd1,  4'd1,  1'b0};
        tbl[7]  = '{16'd1,  64'h0,           1'b0, 0, 4'd1,  4'd0,  1'b0};
        tbl[8]  = '{16'd30, 64'h1555_5555,   1'b0, 1, 4'd15, 4'd15, 1'b0};
        tbl[9]  = '{16'd32, 64'h5555_5555,   1'b0, 0, 4'd15, 4'd15, 1'b1};
        tbl[10] = '{16'd5,  64'h10,          1'b0, 0, 4'd2,  4'd1,  1'b0};
        for (int i = 0; i < 11; i++) run_window(i, tbl[i]);

        // Back-to-back windows: the handshake-cycle edge is not counted
        tick();
        enable = 1'b1; win_len = 16'd3; cnt_ready = 1'b1; pulse_in = 1'b0;
        tick();
        pulse_in = 1'b0; tick();
        pulse_in = 1'b1; tick();
        pulse_in = 1'b0; tick();
        chk("b2b_valid1", 32'(cnt_valid), 32'd1);
        chk("b2b_data1", 32'(cnt_data), 32'd1);
        pulse_in = 1'b1; tick();
        chk("b2b_gap_valid", 32'(cnt_valid), 32'd0);
        chk("b2b_gap_busy", 32'(busy), 32'd1);
        pulse_in = 1'b1; tick();
        pulse_in = 1'b0; tick();
        chk("b2b_mid_valid", 32'(cnt_valid), 32'd0);
        pulse_in = 1'b1; tick();
        chk("b2b_valid2", 32'(cnt_valid), 32'd1);
        chk("b2b_data2", 32'(cnt_data), 32'd1);
        $display("[TB] back-to-back second window data=%0d", cnt_data);
        enable = 1'b0; pulse_in = 1'b0; tick();
        chk("b2b_end_valid", 32'(cnt_valid), 32'd0);
        chk("b2b_end_busy", 32'(busy), 32'd0);

        // Abort on window cycle 5
        enable = 1'b1; win_len = 16'd10; tick();
        for (int j = 0; j < 4; j++) begin
            pulse_in = (j % 2 == 1);
            tick();
        end
        enable = 1'b0; tick();
        chk("abort_busy", 32'(busy), 32'd0);
        for (int j = 0; j < 12; j++) begin
            tick();
            chk("abort_valid", 32'(cnt_valid), 32'd0);
        end
        $display("[TB] abort mid-window, no result");

        // Abort on the final window cycle
        pulse_in = 1'b0;
        enable = 1'b1; win_len = 16'd3; tick();
        pulse_in = 1'b1; tick();
        pulse_in = 1'b0; tick();
        enable = 1'b0; tick();
        chk("abort_last_valid", 32'(cnt_valid), 32'd0);
        chk("abort_last_busy", 32'(busy), 32'd0);
        tick();
        chk("abort_last_valid2", 32'(cnt_valid), 32'd0);

        // Random run against a window-arithmetic reference
        tick();
        tick();
        for (int k = 0; k < N; k++) begin
            p[k]   = 1'($urandom_range(0, 1));
            rdy[k] = ($urandom_range(0, 3) != 0);
            wl[k]  = $urandom_range(0, 40);
        end
`ifdef PULSE_WIN_THRESH_EN
        thresh = 4'd5;
`endif
        s_e   = 0;
        e_e   = (wl[0] == 0) ? 1 : wl[0];
        exp_v = 1'b0;
        exp_d = '0;
        exp_o = 1'b0;
        for (int k = 0; k < N; k++) begin
            enable    = 1'b1;
            pulse_in  = p[k];
            win_len   = 16'(wl[k]);
            cnt_ready = rdy[k];
            tick();
            if (k > e_e && rdy[k]) begin
                exp_v = 1'b0;
                s_e   = k;
                e_e   = k + ((wl[k] == 0) ? 1 : wl[k]);
            end else if (k == e_e) begin
                raw = 0;
                for (int t = s_e + 1; t <= e_e; t++) raw += int'(p[t] && !p[t-1]);
                exp_d = (raw > 15) ? 4'd15 : 4'(raw);
                exp_o = (raw > 15);
                exp_v = 1'b1;
                $display("[TB] random window len=%0d edges=%0d data=%0d ovf=%0d", e_e - s_e, raw, cnt_data, cnt_ovf);
            end
            chk("r_valid", 32'(cnt_valid), 32'(exp_v));
            chk("r_busy", 32'(busy), 32'd1);
            if (exp_v) begin
                chk("r_data", 32'(cnt_data), 32'(exp_d));
                chk("r_ovf", 32'(cnt_ovf), 32'(exp_o));
            end
`ifdef PULSE_WIN_THRESH_EN
            chk("r_alarm", 32'(alarm), 32'(exp_v && (exp_d >= 4'd5)));
`endif
        end
        enable = 1'b0; cnt_ready = 1'b1; pulse_in = 1'b0;
        tick();
        tick();
        cnt_ready = 1'b0;
        chk("r_end_busy", 32'(busy), 32'd0);

        // Reset asserted while a result is held
        enable = 1'b1; win_len = 16'd2; tick();
        pulse_in = 1'b1; tick();
        pulse_in = 1'b0; tick();
        chk("rh_valid", 32'(cnt_valid), 32'd1);
        chk("rh_data", 32'(cnt_data), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rh_rst_valid", 32'(cnt_valid), 32'd0);
        chk("rh_rst_data", 32'(cnt_data), 32'd0);
        chk("rh_rst_ovf", 32'(cnt_ovf), 32'd0);
        chk("rh_rst_busy", 32'(busy), 32'd0);
`ifdef PULSE_WIN_THRESH_EN
        chk("rh_rst_alarm", 32'(alarm), 32'd0);
`endif
        $display("[TB] reset during hold, result dropped");
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rh_after_valid", 32'(cnt_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
